// File: rtl/ocimem_seq_pkg.sv
// Shared types and jdo field positions for the OCI RAM access sequencer.
package ocimem_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    typedef enum logic {
        REQ_JTAG = 1'b0,
        REQ_CPU  = 1'b1
    } req_e;

    localparam int JDO_RD_BIT      = 34;
    localparam int JDO_CLR_ERR_BIT = 35;
    localparam int JDO_DATA_LSB    = 3;
    localparam int JDO_ADDR_LSB    = 2;

endpackage

// File: rtl/ocimem_access_sequencer_if.sv
// CPU Avalon-MM debug slave bus plus the OCI RAM port; slave = sequencer side.
interface ocimem_access_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic [3:0]        avs_byteenable;
    logic [31:0]       avs_readdata;
    logic              avs_waitrequest;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wren;
    logic [31:0]       ram_wdata;
    logic [3:0]        ram_byteen;
    logic [31:0]       ram_rdata;

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable, ram_rdata,
        output avs_readdata, avs_waitrequest, ram_addr, ram_wren, ram_wdata, ram_byteen
    );

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable, ram_rdata,
        input  avs_readdata, avs_waitrequest, ram_addr, ram_wren, ram_wdata, ram_byteen
    );
endinterface

// File: rtl/ocimem_rr_arb.sv
// Two-requester round-robin grant; grant is combinational, last_grant is
// updated only when advance is high and someone is requesting.
module ocimem_rr_arb
    import ocimem_seq_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_jtag,
    input  logic req_cpu,
    input  logic advance,
    output logic gnt_vld,
    output req_e gnt
);
    req_e last_grant_q;
    req_e last_grant_d;

    always_comb begin
        gnt_vld = req_jtag | req_cpu;
        if (req_jtag && req_cpu) begin
            gnt = (last_grant_q == REQ_CPU) ? REQ_JTAG : REQ_CPU;
        end else if (req_jtag) begin
            gnt = REQ_JTAG;
        end else begin
            gnt = REQ_CPU;
        end
        last_grant_d = last_grant_q;
        if (advance && gnt_vld) begin
            last_grant_d = gnt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= REQ_CPU;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/ocimem_access_sequencer.sv
// Shares OCI RAM between JTAG ocimem commands and the CPU debug slave; write 3 / read 4 cycles.
// CPU is stalled via avs_waitrequest; JTAG strobes while a command is outstanding set monitor_error. OCIMEM_PROTECT_EN guards low RAM from CPU writes.
module ocimem_access_sequencer
    import ocimem_seq_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int ROM_WORDS = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      take_action_ocimem_a,
    input  logic                      take_action_ocimem_b,
    input  logic                      take_no_action_ocimem_a,
    input  logic [37:0]               jdo,
    ocimem_access_sequencer_if.slave  bus,
    output logic [31:0]               MonDReg,
    output logic [ADDR_W-1:0]         MonAReg,
    output logic                      monitor_ready,
    output logic                      monitor_error
);
`ifdef OCIMEM_PROTECT_EN
    localparam bit ProtEn = 1'b1;
`else
    localparam bit ProtEn = 1'b0;
`endif

    state_e            state_q, state_d;
    req_e              cur_req_q, cur_req_d;
    logic              cur_wr_q, cur_wr_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]       ram_wdata_q, ram_wdata_d;
    logic [3:0]        ram_byteen_q, ram_byteen_d;
    logic              ram_wren_q, ram_wren_d;
    logic              waitreq_q, waitreq_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       mon_dreg_q, mon_dreg_d;
    logic [ADDR_W-1:0] mon_areg_q, mon_areg_d;
    logic              ready_q, ready_d;
    logic              error_q, error_d;
    logic              pending_q, pending_d;
    logic              pend_wr_q, pend_wr_d;

    logic              st_a, st_b, st_n, any_strobe, overrun, accept, queue_now;
    logic [ADDR_W-1:0] new_addr;
    logic [31:0]       new_data;
    logic              req_jtag, req_cpu, gnt_vld, done_entry, cpu_wr_blocked;
    req_e              gnt;
    logic              unused_jdo;

    assign unused_jdo = ^{jdo[37:36], jdo[1:0]};

    // Only one strobe is honoured per cycle: b beats a beats no_action.
    assign st_b       = take_action_ocimem_b;
    assign st_a       = take_action_ocimem_a & ~st_b;
    assign st_n       = take_no_action_ocimem_a & ~take_action_ocimem_b & ~take_action_ocimem_a;
    assign any_strobe = st_a | st_b | st_n;
    assign overrun    = any_strobe & pending_q;
    assign accept     = any_strobe & ~pending_q;
    assign queue_now  = accept & (st_b | st_n | (st_a & jdo[JDO_RD_BIT]));
    assign new_addr   = st_a ? jdo[ADDR_W+JDO_ADDR_LSB-1:JDO_ADDR_LSB] : mon_areg_q;
    assign new_data   = st_b ? jdo[JDO_DATA_LSB+31:JDO_DATA_LSB] : mon_dreg_q;

    // A fresh strobe competes in the same cycle, so an idle JTAG write completes in 3 cycles.
    assign req_jtag       = pending_q | queue_now;
    assign req_cpu        = bus.avs_read | bus.avs_write;
    assign cpu_wr_blocked = ProtEn && (32'(bus.avs_address) < ROM_WORDS);

    ocimem_rr_arb u_arb (
        .clk      (clk),
        .reset    (reset),
        .req_jtag (req_jtag),
        .req_cpu  (req_cpu),
        .advance  (state_q == ST_IDLE),
        .gnt_vld  (gnt_vld),
        .gnt      (gnt)
    );

    always_comb begin
        state_d      = state_q;
        cur_req_d    = cur_req_q;
        cur_wr_d     = cur_wr_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        ram_byteen_d = ram_byteen_q;
        ram_wren_d   = 1'b0;
        waitreq_d    = 1'b1;
        rdata_d      = rdata_q;
        mon_dreg_d   = mon_dreg_q;
        mon_areg_d   = mon_areg_q;
        ready_d      = ready_q;
        error_d      = error_q;
        pending_d    = pending_q;
        pend_wr_d    = pend_wr_q;
        done_entry   = 1'b0;

        if (overrun) begin
            error_d = 1'b1;
        end else if (accept && st_a && jdo[JDO_CLR_ERR_BIT]) begin
            error_d = 1'b0;
        end
        if (accept && st_a) mon_areg_d = new_addr;
        if (accept && st_b) mon_dreg_d = new_data;
        if (queue_now) begin
            pending_d = 1'b1;
            ready_d   = 1'b0;
            pend_wr_d = st_b;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    state_d   = ST_ACCESS;
                    cur_req_d = gnt;
                    if (gnt == REQ_JTAG) begin
                        ram_addr_d   = queue_now ? new_addr : mon_areg_q;
                        ram_wdata_d  = queue_now ? new_data : mon_dreg_q;
                        ram_byteen_d = 4'hF;
                        cur_wr_d     = queue_now ? st_b : pend_wr_q;
                        ram_wren_d   = cur_wr_d;
                    end else begin
                        ram_addr_d   = bus.avs_address;
                        ram_wdata_d  = bus.avs_writedata;
                        ram_byteen_d = bus.avs_byteenable;
                        cur_wr_d     = bus.avs_write;
                        ram_wren_d   = bus.avs_write & ~cpu_wr_blocked;
                    end
                end
            end
            ST_ACCESS: begin
                if (cur_wr_q) begin
                    state_d    = ST_DONE;
                    done_entry = 1'b1;
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                state_d    = ST_DONE;
                done_entry = 1'b1;
                if (cur_req_q == REQ_JTAG) begin
                    mon_dreg_d = bus.ram_rdata;
                end else begin
                    rdata_d = bus.ram_rdata;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Completion flags are registered on entry so they are visible during DONE.
        if (done_entry) begin
            if (cur_req_q == REQ_CPU) begin
                waitreq_d = 1'b0;
            end else begin
                ready_d    = 1'b1;
                pending_d  = 1'b0;
                mon_areg_d = mon_areg_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cur_req_q    <= REQ_CPU;
            cur_wr_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            ram_byteen_q <= '0;
            ram_wren_q   <= 1'b0;
            waitreq_q    <= 1'b1;
            rdata_q      <= '0;
            mon_dreg_q   <= '0;
            mon_areg_q   <= '0;
            ready_q      <= 1'b0;
            error_q      <= 1'b0;
            pending_q    <= 1'b0;
            pend_wr_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_req_q    <= cur_req_d;
            cur_wr_q     <= cur_wr_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            ram_byteen_q <= ram_byteen_d;
            ram_wren_q   <= ram_wren_d;
            waitreq_q    <= waitreq_d;
            rdata_q      <= rdata_d;
            mon_dreg_q   <= mon_dreg_d;
            mon_areg_q   <= mon_areg_d;
            ready_q      <= ready_d;
            error_q      <= error_d;
            pending_q    <= pending_d;
            pend_wr_q    <= pend_wr_d;
        end
    end

    assign bus.ram_addr        = ram_addr_q;
    assign bus.ram_wdata       = ram_wdata_q;
    assign bus.ram_byteen      = ram_byteen_q;
    assign bus.ram_wren        = ram_wren_q;
    assign bus.avs_waitrequest = waitreq_q;
    assign bus.avs_readdata    = rdata_q;
    assign MonDReg             = mon_dreg_q;
    assign MonAReg             = mon_areg_q;
    assign monitor_ready       = ready_q;
    assign monitor_error       = error_q;

endmodule
